mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (I side) and the execute stage's load/store path (D side).
- Arbitrates competing requests and launches one transaction at a time.
- Waits for the memory acknowledge and routes the returned word back to the owning requester.
- Data has priority, since an outstanding load stalls the pipeline. A streak limit keeps fetch from starving, and a timeout recovers from a hung memory.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Groups the request, response and memory-bus signals of the shared memory
//   port. The slave modport is the arbiter's view. The master modport is the
//   view of the environment: the requesters and the memory.
//   I side : i_req/i_addr in; i_gnt/i_valid/i_rdata out
//   D side : d_req/d_we/d_addr/d_wdata/d_be in; d_gnt/d_valid/d_rdata out
//   Memory : mem_req/mem_we/mem_addr/mem_wdata/mem_be out; mem_valid/mem_rdata in
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_valid;
    logic [XLEN-1:0] i_rdata;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_be;
    logic            d_gnt;
    logic            d_valid;
    logic [XLEN-1:0] d_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_valid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_valid, mem_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_valid, mem_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between instruction fetch (I) and load/store (D).
//   Only one transaction is in flight at a time. D wins arbitration, except
//   after MAX_D_STREAK consecutive D grants made while I was waiting. A
//   transaction with no mem_valid for TIMEOUT cycles is aborted: it returns
//   zero data and sets the sticky err flag.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : request/response/memory signals (slave modport)
//   busy  : a transaction is outstanding
//   err   : sticky timeout flag
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                err
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] streak;
    logic [TW-1:0] timer;
    logic          grant_i, grant_d, done, expire;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and arbitration decision
    always_comb begin
        grant_d  = (state == IDLE) && bus.d_req &&
                   (!bus.i_req || (streak < STREAK_MAX));
        grant_i  = (state == IDLE) && !grant_d && bus.i_req;
        done     = (state != IDLE) && bus.mem_valid;
        expire   = (state != IDLE) && !bus.mem_valid && (timer == TIMER_LAST);
        state_nx = state;
        case (state)
            IDLE:    if (grant_d)      state_nx = WAIT_D;
                     else if (grant_i) state_nx = WAIT_I;
            WAIT_I,
            WAIT_D:  if (done || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Registered pulses, memory-bus latches, return data and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.i_gnt     <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.i_valid   <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= 4'b0000;
            err           <= 1'b0;
            streak        <= '0;
            timer         <= '0;
        end else begin
            bus.i_gnt   <= grant_i;
            bus.d_gnt   <= grant_d;
            bus.mem_req <= grant_i | grant_d;
            bus.i_valid <= (state == WAIT_I) && (done || expire);
            bus.d_valid <= (state == WAIT_D) && (done || expire);
            err         <= err | expire;

            if (grant_d) begin
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
                bus.mem_be    <= bus.d_be;
            end else if (grant_i) begin
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.i_addr;
                bus.mem_wdata <= '0;
                bus.mem_be    <= 4'b1111;
            end

            // A timed-out transaction returns zero. An ack has priority over
            // the timeout when both land on the same edge.
            if (state == WAIT_I) begin
                if (done)        bus.i_rdata <= bus.mem_rdata;
                else if (expire) bus.i_rdata <= '0;
            end
            if (state == WAIT_D) begin
                if (done)        bus.d_rdata <= bus.mem_rdata;
                else if (expire) bus.d_rdata <= '0;
            end

            if (grant_i || grant_d || done || expire) timer <= '0;
            else if (state != IDLE)                    timer <= timer + 1'b1;

            // The streak counts only D grants that bypassed a waiting fetch.
            if (!bus.i_req || grant_i)               streak <= '0;
            else if (grant_d && streak < STREAK_MAX) streak <= streak + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, err;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_arbiter_if #(.XLEN(XLEN)) bus();

    mem_port_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_valid = 0; bus.mem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_memreq", bus.mem_req, 0);
        chk("rst_err", err, 0);
        chk("rst_irdata", bus.i_rdata, 0);
        chk("rst_drdata", bus.d_rdata, 0);
        chk("rst_memaddr", bus.mem_addr, 0);
        chk("rst_membe", bus.mem_be, 0);
        reset = 0;
        tick();

        // Single load, ack two cycles after mem_req
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.d_wdata = 32'h5A5A5A5A; bus.d_be = 4'hF;
        tick();
        chk("ld_dgnt", bus.d_gnt, 1);
        chk("ld_ignt", bus.i_gnt, 0);
        chk("ld_memreq", bus.mem_req, 1);
        chk("ld_memaddr", bus.mem_addr, 32'h100);
        chk("ld_memwe", bus.mem_we, 0);
        chk("ld_busy", busy, 1);
        bus.d_req = 0;
        tick();
        chk("ld_gnt_pulse", bus.d_gnt, 0);
        chk("ld_memreq_pulse", bus.mem_req, 0);
        chk("ld_dvalid_early", bus.d_valid, 0);
        bus.mem_valid = 1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_valid = 0;
        chk("ld_dvalid", bus.d_valid, 1);
        chk("ld_drdata", bus.d_rdata, 32'hDEADBEEF);
        chk("ld_ivalid", bus.i_valid, 0);
        chk("ld_idle", busy, 0);
        tick();
        chk("ld_dvalid_pulse", bus.d_valid, 0);

        // Store
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
        tick();
        chk("st_dgnt", bus.d_gnt, 1);
        chk("st_memwe", bus.mem_we, 1);
        chk("st_memaddr", bus.mem_addr, 32'h40);
        chk("st_memwdata", bus.mem_wdata, 32'h12345678);
        chk("st_membe", bus.mem_be, 4'b0011);
        bus.d_req = 0; bus.d_we = 0;
        bus.mem_valid = 1; bus.mem_rdata = 32'hAAAA5555;
        tick();
        bus.mem_valid = 0;
        chk("st_dvalid", bus.d_valid, 1);
        chk("st_drdata", bus.d_rdata, 32'hAAAA5555);

        // Contention: expected grant order D,D,D,D,I,D with ack latency 1
        bus.i_req = 1; bus.i_addr = 32'h200;
        bus.d_req = 1; bus.d_addr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            logic exp_i;
            exp_i = (k == 4);
            tick();
            chk($sformatf("cont_ignt%0d", k), bus.i_gnt, exp_i);
            chk($sformatf("cont_dgnt%0d", k), bus.d_gnt, !exp_i);
            chk($sformatf("cont_addr%0d", k), bus.mem_addr, exp_i ? 32'h200 : 32'h300);
            bus.mem_valid = 1; bus.mem_rdata = 32'h1000 + k;
            tick();
            bus.mem_valid = 0;
            chk($sformatf("cont_ivalid%0d", k), bus.i_valid, exp_i);
            chk($sformatf("cont_dvalid%0d", k), bus.d_valid, !exp_i);
        end
        bus.i_req = 0; bus.d_req = 0;
        tick();

        // Fetch only: the I read drives be=1111, we=0 and wdata=0
        bus.d_wdata = 32'hFFFF0000;
        bus.i_req = 1; bus.i_addr = 32'h0;
        tick();
        chk("if_ignt", bus.i_gnt, 1);
        chk("if_membe", bus.mem_be, 4'hF);
        chk("if_memwe", bus.mem_we, 0);
        chk("if_memwdata", bus.mem_wdata, 0);
        chk("if_memaddr", bus.mem_addr, 0);
        bus.i_req = 0;
        bus.mem_valid = 1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_valid = 0;
        chk("if_ivalid", bus.i_valid, 1);
        chk("if_irdata", bus.i_rdata, 32'hCAFEF00D);
        chk("if_dvalid", bus.d_valid, 0);

        // Timeout: TIMEOUT=8, so d_valid comes 8 edges after the grant
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
        tick();
        chk("to_dgnt", bus.d_gnt, 1);
        bus.d_req = 0;
        for (int k = 1; k < 8; k++) tick();
        chk("to_busy7", busy, 1);
        chk("to_dvalid7", bus.d_valid, 0);
        chk("to_err7", err, 0);
        tick();
        chk("to_dvalid", bus.d_valid, 1);
        chk("to_drdata", bus.d_rdata, 0);
        chk("to_err", err, 1);
        chk("to_idle", busy, 0);
        // A late ack arriving in IDLE is ignored
        bus.mem_valid = 1; bus.mem_rdata = 32'h11111111;
        tick();
        bus.mem_valid = 0;
        chk("late_dvalid", bus.d_valid, 0);
        chk("late_ivalid", bus.i_valid, 0);
        chk("late_drdata", bus.d_rdata, 0);
        chk("late_busy", busy, 0);
        // err stays set through a normal transaction
        bus.i_req = 1; bus.i_addr = 32'h4;
        tick();
        bus.i_req = 0;
        bus.mem_valid = 1; bus.mem_rdata = 32'h22222222;
        tick();
        bus.mem_valid = 0;
        chk("sticky_ivalid", bus.i_valid, 1);
        chk("sticky_err", err, 1);

        // Reset while waiting on a D transaction
        bus.d_req = 1; bus.d_addr = 32'h500;
        tick();
        chk("rm_dgnt", bus.d_gnt, 1);
        bus.d_req = 0;
        tick();
        chk("rm_busy", busy, 1);
        #1 reset = 1;
        #1;
        chk("rm_busy_async", busy, 0);
        chk("rm_memreq_async", bus.mem_req, 0);
        chk("rm_dvalid_async", bus.d_valid, 0);
        chk("rm_err_async", err, 0);
        tick();
        reset = 0;
        bus.mem_valid = 1; bus.mem_rdata = 32'h33333333;
        tick();
        bus.mem_valid = 0;
        chk("rm_stray_dvalid", bus.d_valid, 0);
        chk("rm_stray_busy", busy, 0);
        chk("rm_stray_drdata", bus.d_rdata, 0);
        bus.i_req = 1; bus.i_addr = 32'h600;
        tick();
        chk("rm_ignt", bus.i_gnt, 1);
        chk("rm_iaddr", bus.mem_addr, 32'h600);
        bus.i_req = 0;
        bus.mem_valid = 1; bus.mem_rdata = 32'h44444444;
        tick();
        bus.mem_valid = 0;
        chk("rm_ivalid", bus.i_valid, 1);
        chk("rm_irdata", bus.i_rdata, 32'h44444444);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
